// File: rtl/jelly_data_pkg.sv
// Shared definitions for the jelly data-stream blocks (framer, width converter).
package jelly_data_pkg;

  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefLenWidth  = 16;
  localparam int unsigned DefCntWidth  = 32;

  // Every data/flag bit of a pipeline register resets to this value.
  localparam logic DataResetBit = 1'b0;

  // One tagged stream word as held in the pipeline and skid registers.
  typedef struct packed {
    logic [DefDataWidth-1:0] data;
    logic                    first;
    logic                    last;
  } data_word_t;

endpackage

// File: rtl/jelly_data_skid_buffer.sv
// Two-entry registered valid/ready slice: output register plus skid register.
// s_ready_o is a flop output and never depends combinationally on m_ready_i.
import jelly_data_pkg::*;

module jelly_data_skid_buffer #(
  parameter type word_t = data_word_t
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  cke_i,
  input  word_t s_word_i,
  input  logic  s_valid_i,
  output logic  s_ready_o,
  output word_t m_word_o,
  output logic  m_valid_o,
  input  logic  m_ready_i
);

  localparam word_t ResetWord = word_t'({$bits(word_t){DataResetBit}});

  word_t out_q, out_d;
  word_t skid_q, skid_d;
  logic  out_valid_q, out_valid_d;
  logic  skid_valid_q, skid_valid_d;
  logic  ready_q, ready_d;
  logic  s_xfer, m_xfer;

  assign s_xfer = cke_i & s_valid_i & ready_q;
  assign m_xfer = cke_i & out_valid_q & m_ready_i;

  // Next-state: fill the output register first, spill into skid when it is stalled.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (skid_valid_q) begin
      // ready_q is low here, so only the drain side can move.
      if (m_xfer) begin
        out_d        = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (s_xfer) begin
      if (!out_valid_q || m_xfer) begin
        out_d       = s_word_i;
        out_valid_d = 1'b1;
      end else begin
        skid_d       = s_word_i;
        skid_valid_d = 1'b1;
      end
    end else if (m_xfer) begin
      out_valid_d = 1'b0;
    end
    ready_d = ~skid_valid_d;
  end

  // State registers; everything holds while cke_i is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q        <= ResetWord;
      out_valid_q  <= 1'b0;
      skid_q       <= ResetWord;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else if (cke_i) begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
    end
  end

  assign s_ready_o = ready_q;
  assign m_word_o  = out_q;
  assign m_valid_o = out_valid_q;

endmodule

// File: rtl/jelly_data_framer.sv
// Attaches first/last flags to an unframed word stream using a programmable
// frame length, then registers the result through a skid buffer.
import jelly_data_pkg::*;

module jelly_data_framer #(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned LEN_WIDTH  = DefLenWidth,
  parameter int unsigned CNT_WIDTH  = DefCntWidth
) (
  input  logic                  reset_n,
  input  logic                  clk,
  input  logic                  cke,
  input  logic [LEN_WIDTH-1:0]  param_len,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_first,
  output logic                  m_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  in_frame,
  output logic [CNT_WIDTH-1:0]  frame_count
);

  // Same shape as data_word_t, sized to this instance's data width.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  first;
    logic                  last;
  } word_t;

  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [CNT_WIDTH-1:0] frame_count_q, frame_count_d;
  logic                 s_xfer, m_xfer;
  logic                 tag_first, tag_last;
  word_t                in_word, out_word;

  assign s_xfer = cke & s_valid & s_ready;
  assign m_xfer = cke & m_valid & m_ready;

  // Tag the presented word; a new frame samples param_len, later words use len_q.
  always_comb begin
    tag_first = (cnt_q == '0);
    tag_last  = (cnt_q == '0) ? (param_len == '0) : (cnt_q == len_q);
    in_word.data  = s_data;
    in_word.first = tag_first;
    in_word.last  = tag_last;
  end

  // Word counter, latched length and completed-frame counter next-state.
  always_comb begin
    cnt_d         = cnt_q;
    len_d         = len_q;
    frame_count_d = frame_count_q;
    if (s_xfer) begin
      if (cnt_q == '0) begin
        len_d = param_len;
      end
      cnt_d = tag_last ? '0 : cnt_q + 1'b1;
    end
    if (m_xfer && out_word.last) begin
      frame_count_d = frame_count_q + 1'b1;
    end
  end

  // Counter state; held while cke is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q         <= '0;
      len_q         <= '0;
      frame_count_q <= '0;
    end else if (cke) begin
      cnt_q         <= cnt_d;
      len_q         <= len_d;
      frame_count_q <= frame_count_d;
    end
  end

  jelly_data_skid_buffer #(
    .word_t (word_t)
  ) u_skid (
    .clk_i     (clk),
    .rst_ni    (reset_n),
    .cke_i     (cke),
    .s_word_i  (in_word),
    .s_valid_i (s_valid),
    .s_ready_o (s_ready),
    .m_word_o  (out_word),
    .m_valid_o (m_valid),
    .m_ready_i (m_ready)
  );

  assign m_data      = out_word.data;
  assign m_first     = out_word.first;
  assign m_last      = out_word.last;
  assign in_frame    = (cnt_q != '0);
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_jelly_data_framer.sv
// Directed bench for jelly_data_framer: table-driven framing vectors plus
// hand-written back-pressure, random-handshake and async-reset sequences.
module tb_jelly_data_framer;

  logic        reset_n;
  logic        clk;
  logic        cke;
  logic [15:0] param_len;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] m_data;
  logic        m_first;
  logic        m_last;
  logic        m_valid;
  logic        m_ready;
  logic        in_frame;
  logic [31:0] frame_count;

  int checks = 0;
  int errors = 0;

  jelly_data_framer dut (
    .reset_n     (reset_n),
    .clk         (clk),
    .cke         (cke),
    .param_len   (param_len),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .m_data      (m_data),
    .m_first     (m_first),
    .m_last      (m_last),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .in_frame    (in_frame),
    .frame_count (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [15:0] plen;
    logic        first;
    logic        last;
  } vec_t;

  vec_t vt[25];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [31:0] d, input logic [15:0] p,
                         input logic f, input logic l);
    vt[i].data  = d;
    vt[i].plen  = p;
    vt[i].first = f;
    vt[i].last  = l;
  endtask

  // Stream table entries [start, start+n) with cke=1 and m_ready=1.
  task automatic run_table(input int start, input int n, output int cycles);
    int in_idx;
    int out_idx;
    bit pend;
    in_idx  = 0;
    out_idx = 0;
    pend    = 1'b0;
    cycles  = 0;
    while (out_idx < n && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (pend) in_idx++;
      if (m_valid && m_ready) begin
        chk("table_data",  m_data,  vt[start+out_idx].data);
        chk("table_first", m_first, vt[start+out_idx].first);
        chk("table_last",  m_last,  vt[start+out_idx].last);
        out_idx++;
      end
      s_valid = (in_idx < n);
      if (in_idx < n) begin
        s_data    = vt[start+in_idx].data;
        param_len = vt[start+in_idx].plen;
      end
      pend = s_valid && s_ready;
    end
    s_valid = 1'b0;
    chk("table_words_out", out_idx, n);
  endtask

  // Stream base+in_start .. base+n-1; expects base+0 .. base+n-1 out, framed by plen.
  task automatic stream(input int base, input int n, input int in_start,
                        input int plen, input bit rnd);
    int in_idx;
    int out_idx;
    int cyc;
    bit pend;
    in_idx  = in_start;
    out_idx = 0;
    cyc     = 0;
    pend    = 1'b0;
    while (out_idx < n && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (pend) in_idx++;
      cke     = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      m_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (cke && m_valid && m_ready) begin
        chk("stream_data",  m_data,  base + out_idx);
        chk("stream_first", m_first, (out_idx % (plen + 1)) == 0);
        chk("stream_last",  m_last,  (out_idx % (plen + 1)) == plen);
        out_idx++;
      end
      s_valid   = (in_idx < n) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      s_data    = base + in_idx;
      param_len = plen[15:0];
      pend      = cke && s_valid && s_ready;
    end
    cke     = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b1;
    chk("stream_words_out", out_idx, n);
  endtask

  initial begin
    int  cycles;
    int  acc;
    bit  pend;
    bit  stable;

    // 12 words, param_len=3
    for (int i = 0; i < 12; i++) begin
      set_vec(i, i, 16'd3, (i % 4) == 0, (i % 4) == 3);
    end
    // 5 words, param_len=0
    set_vec(12, 32'd12, 16'd0, 1'b1, 1'b1);
    set_vec(13, 32'd13, 16'd0, 1'b1, 1'b1);
    set_vec(14, 32'd14, 16'd0, 1'b1, 1'b1);
    set_vec(15, 32'd15, 16'd0, 1'b1, 1'b1);
    set_vec(16, 32'd16, 16'd0, 1'b1, 1'b1);
    // param_len 3 -> 1 after the second word: frame of 4, then frames of 2
    set_vec(17, 32'd20, 16'd3, 1'b1, 1'b0);
    set_vec(18, 32'd21, 16'd3, 1'b0, 1'b0);
    set_vec(19, 32'd22, 16'd1, 1'b0, 1'b0);
    set_vec(20, 32'd23, 16'd1, 1'b0, 1'b1);
    set_vec(21, 32'd24, 16'd1, 1'b1, 1'b0);
    set_vec(22, 32'd25, 16'd1, 1'b0, 1'b1);
    set_vec(23, 32'd26, 16'd1, 1'b1, 1'b0);
    set_vec(24, 32'd27, 16'd1, 1'b0, 1'b1);

    reset_n   = 1'b0;
    cke       = 1'b1;
    param_len = 16'd3;
    s_data    = '0;
    s_valid   = 1'b0;
    m_ready   = 1'b1;

    #12;
    chk("rst_m_valid",     m_valid,     1'b0);
    chk("rst_s_ready",     s_ready,     1'b0);
    chk("rst_m_data",      m_data,      32'd0);
    chk("rst_m_first",     m_first,     1'b0);
    chk("rst_m_last",      m_last,      1'b0);
    chk("rst_in_frame",    in_frame,    1'b0);
    chk("rst_frame_count", frame_count, 32'd0);

    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_s_ready", s_ready, 1'b1);

    // Continuous stream: first output one cycle after first accept, then one per cycle.
    run_table(0, 12, cycles);
    chk("len3_cycles", cycles, 13);
    @(negedge clk);
    chk("len3_frame_count", frame_count, 32'd3);
    chk("len3_in_frame",    in_frame,    1'b0);

    run_table(12, 5, cycles);
    @(negedge clk);
    chk("len0_frame_count", frame_count, 32'd8);

    run_table(17, 8, cycles);
    @(negedge clk);
    chk("lenchg_frame_count", frame_count, 32'd11);
    chk("lenchg_in_frame",    in_frame,    1'b0);

    // Back-pressure: m_ready low for 10 cycles while s_valid stays high.
    m_ready = 1'b0;
    acc     = 0;
    pend    = 1'b0;
    stable  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (pend) acc++;
      if (i >= 1 && (m_valid !== 1'b1 || m_data !== 32'd100 ||
                     m_first !== 1'b1 || m_last !== 1'b0)) begin
        stable = 1'b0;
      end
      s_valid   = 1'b1;
      s_data    = 32'd100 + acc;
      param_len = 16'd3;
      pend      = s_valid && s_ready;
    end
    s_valid = 1'b0;
    chk("bp_accepted", acc,     2);
    chk("bp_s_ready",  s_ready, 1'b0);
    chk("bp_stable",   stable,  1'b1);
    chk("bp_in_frame", in_frame, 1'b1);
    stream(100, 4, 2, 3, 1'b0);
    @(negedge clk);
    chk("bp_frame_count", frame_count, 32'd12);

    // Random cke / m_ready / s_valid, 63 full frames of 16.
    stream(0, 1008, 0, 15, 1'b1);
    @(negedge clk);
    chk("rnd_frame_count", frame_count, 32'd75);
    chk("rnd_in_frame",    in_frame,    1'b0);

    // Async reset in the middle of a 4-word frame.
    stream(200, 2, 0, 3, 1'b0);
    @(negedge clk);
    chk("mid_in_frame", in_frame, 1'b1);
    m_ready   = 1'b0;
    s_valid   = 1'b1;
    s_data    = 32'd202;
    param_len = 16'd3;
    @(negedge clk);
    s_valid = 1'b0;
    chk("mid_m_data",  m_data,  32'd202);
    chk("mid_m_valid", m_valid, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_m_valid",     m_valid,     1'b0);
    chk("arst_m_data",      m_data,      32'd0);
    chk("arst_s_ready",     s_ready,     1'b0);
    chk("arst_in_frame",    in_frame,    1'b0);
    chk("arst_frame_count", frame_count, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    stream(300, 2, 0, 1, 1'b0);
    @(negedge clk);
    chk("post_rst_frame_count", frame_count, 32'd1);
    chk("post_rst_in_frame",    in_frame,    1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jelly_data_framer.md
Name: jelly_data_framer

Overview:
- Frame-marking stage directly upstream of jelly_data_width_converter.
- Takes an unframed valid/ready word stream and attaches first/last flags using a programmable frame length, so the converter's s_first/s_last inputs are driven from a single counter.
- Output is registered: one pipeline register plus a skid register, giving full throughput under back-pressure.
- Also reports the frame count and mid-frame status for debug/CSR use.

Parameters:
- DATA_WIDTH, 32, width of s_data/m_data in bits.
- LEN_WIDTH, 16, width of the frame-length and word-counter fields.
- CNT_WIDTH, 32, width of the completed-frame counter.

Ports:
- reset_n  input  1  asynchronous active-low reset
- clk  input  1  clock
- cke  input  1  clock enable; when 0, all state holds and no transfer occurs on either side
- param_len  input  LEN_WIDTH  frame length minus 1, in words; sampled only at frame start
- s_data  input  DATA_WIDTH  input word
- s_valid  input  1  input valid
- s_ready  output  1  input ready
- m_data  output  DATA_WIDTH  output word (feeds converter s_data)
- m_first  output  1  first word of frame
- m_last  output  1  last word of frame
- m_valid  output  1  output valid
- m_ready  input  1  output ready
- in_frame  output  1  1 while a frame is partially transferred on the s side
- frame_count  output  CNT_WIDTH  number of frames whose last word has been accepted downstream

Behaviour:
- Reset (reset_n=0, asynchronous): m_valid=0, s_ready=0 during reset, m_data=0, m_first=0, m_last=0, in_frame=0, frame_count=0, word counter=0, skid empty.
- Transfer rules:
  - s transfer = cke & s_valid & s_ready.
  - m transfer = cke & m_valid & m_ready.
- s_ready = !skid_valid, registered. It deasserts the cycle after the skid register fills and reasserts the cycle after the skid drains. s_ready does not depend combinationally on m_ready.
- Latency: an accepted word appears on m_* the next cycle when the output register is empty or being drained. Otherwise it goes into the skid register, and skid contents move to the output register on the next m transfer.
- Word counter (cnt) and latched length (len_q), updated on each s transfer:
  - If cnt==0: len_q<=param_len; word tagged first=1; last=(param_len==0).
  - Else: first=0; last=(cnt==len_q).
  - If the tagged last=1: cnt<=0, else cnt<=cnt+1.
- param_len changes mid-frame have no effect until the next frame start.
- param_len=0: every word is tagged first=1 and last=1.
- in_frame = (cnt!=0).
- frame_count increments by 1 on each m transfer with m_last=1, and wraps modulo 2^CNT_WIDTH.
- m_valid, m_data, m_first and m_last are stable while m_valid=1 and m_ready=0 (AXI-stream rule).
- Simultaneous events:
  - If an s transfer and an m transfer occur in the same cycle with the skid empty, the output register loads the new word directly; no bubble.
  - If the skid is full and an m transfer occurs, the output register loads from the skid and s_ready rises next cycle.
- cke=0: no counter, flag, data or count update, regardless of valid/ready levels.
- Counter wrap: cnt never exceeds len_q; len_q=2^LEN_WIDTH-1 is legal (max frame length).
- Reset mid-frame: all state clears immediately. The next accepted word is first=1 with a freshly sampled param_len.

Decomposition:
- The shared package jelly_data_pkg holds:
  - default widths;
  - a localparam for the reset data value;
  - a struct {data, first, last} used for the pipeline and skid registers, so the converter can reuse it.
- One sub-module is natural: jelly_data_skid_buffer (2-entry registered valid/ready slice carrying the struct, with cke and async active-low reset). The framer adds only the counter/tagging logic in front of it.

Test Plan:
- param_len=3, continuous s_valid, m_ready=1, cke=1, data 0..11: m_first on words 0,4,8; m_last on 3,7,11; frame_count=3; one word per cycle after 1-cycle latency.
- param_len=0, 5 words: every output has first=1 and last=1; frame_count=5.
- param_len=3, change to 1 after word 1 is accepted: words 0–3 form one frame (last on word 3), then frames of 2 (last on words 5, 7).
- m_ready held 0 for 10 cycles with s_valid=1: exactly 2 words accepted, s_ready=0 thereafter, and m_* stable. Releasing m_ready outputs the words in order with no loss or duplication.
- Random cke and random m_ready/s_valid over 1000 words, param_len=15: output matches the incrementing sequence. Flags match data%16==0 for first and data%16==15 for last, so the output is directly compatible with the converter bench's checks.
- reset_n pulse after word 2 of a 4-word frame: outputs clear asynchronously; the next word carries first=1; in_frame=0 and frame_count=0 after reset.
